// File: rtl/stream_upsizer.sv
// stream_upsizer
// Packs RATIO narrow input beats of DW bits into one wide output word.
// A word closes early when an input beat carries last_i. Lanes that were
// never filled are flagged off in keep_o and forced to zero in data_o.
// One output register sits between the packer and the downstream port.
// That register can be reloaded in the same cycle it is drained, so a
// steady stream runs with no bubbles.

module stream_upsizer #(
   parameter int DW    = 8,
   parameter int RATIO = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DW-1:0]         data_i,
   input  logic                  last_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DW*RATIO-1:0]   data_o,
   output logic [RATIO-1:0]      keep_o,
   output logic                  last_o
);

   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

   // Lanes gathered so far for the word being assembled
   logic [DW*RATIO-1:0] r_asm;
   // Index of the lane the next accepted beat will fill
   logic [CW-1:0]       r_cnt;
   // Output register presented to the downstream port
   logic [DW*RATIO-1:0] r_data;
   logic [RATIO-1:0]    r_keep;
   logic                r_last;
   logic                r_valid;

   logic                w_ready;
   logic                w_accept;
   logic                w_complete;
   logic                w_outHs;
   logic                w_lastLane;
   logic [DW*RATIO-1:0] w_word;
   logic [RATIO-1:0]    w_keep;
   logic [DW*RATIO-1:0] w_asmNext;

   // The output register can always take a new word when it is empty or
   // being drained this cycle, so ready never looks at the upstream side
   assign w_ready    = ~r_valid | ready_i;
   assign w_accept   = valid_i & w_ready;
   assign w_outHs    = r_valid & ready_i;
   assign w_lastLane = (r_cnt == CW'(RATIO - 1));
   assign w_complete = w_accept & (w_lastLane | last_i);

   assign ready_o = w_ready;
   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign keep_o  = r_keep;
   assign last_o  = r_last;

   // Build the candidate output word: lanes below the counter come from the
   // assembly register, the counter lane takes the incoming beat, and the
   // lanes above it are zero and marked empty
   always_comb begin
      w_word    = '0;
      w_keep    = '0;
      w_asmNext = r_asm;
      for (int k = 0; k < RATIO; k++) begin
         if (CW'(k) < r_cnt) begin
            w_word[k*DW +: DW] = r_asm[k*DW +: DW];
            w_keep[k]          = 1'b1;
         end else if (CW'(k) == r_cnt) begin
            w_word[k*DW +: DW]    = data_i;
            w_keep[k]             = 1'b1;
            w_asmNext[k*DW +: DW] = data_i;
         end
      end
   end

   // Assembly side: store accepted beats and advance or wrap the lane counter.
   // A flush drops the partial word and blocks that cycle's handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_asm <= '0;
         r_cnt <= '0;
      end else if (clear_i) begin
         r_asm <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_asm <= w_asmNext;
         if (w_complete) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Output side: a completing beat loads the new word, even while the old
   // word drains in the same cycle. A drain with no new word empties it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_data  <= '0;
         r_keep  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (clear_i) begin
         r_data  <= '0;
         r_keep  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_complete) begin
         r_data  <= w_word;
         r_keep  <= w_keep;
         r_last  <= last_i;
         r_valid <= 1'b1;
      end else if (w_outHs) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter DW, default 8: width of one input beat in bits.
REQ-002 SHALL have parameter RATIO, default 4: input beats per output word; legal range 2..16.
REQ-003 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port clear_i  input  1: synchronous flush of all held data.
REQ-006 SHALL have port valid_i  input  1: upstream beat valid.
REQ-007 SHALL have port ready_o  output  1: this block accepts the upstream beat.
REQ-008 SHALL have port data_i  input  DW: upstream beat payload.
REQ-009 SHALL have port last_i  input  1: the beat is the final beat of a packet.
REQ-010 SHALL have port valid_o  output  1: output word valid.
REQ-011 SHALL have port ready_i  input  1: downstream accepts the output word.
REQ-012 SHALL have port data_o  output  DW*RATIO: packed output word.
REQ-013 SHALL have port keep_o  output  RATIO: per-lane valid mask of data_o.
REQ-014 SHALL have port last_o  output  1: the output word ends a packet.

Function
REQ-015 SHALL transfer an input beat when valid_i and ready_o are both high at a rising edge, and an output word when valid_o and ready_i are both high.
REQ-016 SHALL hold an assembly register of RATIO lanes, a lane counter cnt (width clog2(RATIO)), and an output register holding data_o, keep_o, last_o and valid_o.
REQ-017 SHALL write an accepted beat into assembly lane cnt; lane 0 occupies data bits [DW-1:0]; the first beat of a word goes in lane 0.
REQ-018 SHALL treat an accepted beat as completing a word when cnt == RATIO-1 or last_i == 1.
REQ-019 On a non-completing accepted beat: SHALL increment cnt by 1 and leave the output register unchanged.
REQ-020 On a completing accepted beat: SHALL load the output register the next cycle with the assembled lanes plus the current beat, set valid_o, and set cnt to 0.
REQ-021 SHALL set keep_o bit k to 1 for lanes 0..cnt of the completing beat and to 0 above it.
REQ-022 SHALL drive lanes whose keep_o bit is 0 to zero in data_o.
REQ-023 SHALL set last_o equal to last_i of the completing beat.
REQ-024 SHALL drive ready_o = ~valid_o | ready_i, combinationally; ready_o SHALL NOT depend on valid_i, data_i or last_i.
REQ-025 SHALL have a latency of exactly 1 cycle from acceptance of a completing beat to valid_o high.
REQ-026 SHALL sustain one beat per cycle while ready_i stays high, giving one output word every RATIO input beats for full words.
REQ-027 When an output handshake and a completing beat occur in the same cycle, SHALL reload the output register with the new word; valid_o SHALL stay high with no bubble.
REQ-028 When an output handshake occurs with no completing beat, SHALL clear valid_o the next cycle.
REQ-029 While valid_o is high and ready_i is low, SHALL hold data_o, keep_o and last_o stable and keep valid_o high.
REQ-030 SHALL hold ready_o low in that stalled state, so the assembly register is not modified.
REQ-031 When clear_i is high at a rising edge, SHALL set cnt to 0, valid_o to 0, keep_o to 0 and last_o to 0, discarding any partial word.
REQ-032 SHALL ignore any input or output handshake in a cycle where clear_i is high.
REQ-033 SHALL give rst_i priority over clear_i.

Reset
REQ-034 When rst_i is high at a rising edge: SHALL set valid_o=0, data_o=0, keep_o=0, last_o=0, cnt=0 and assembly register=0.
REQ-035 ready_o SHALL read 1 in the cycle after reset is released.
REQ-036 Reset asserted mid-packet SHALL discard the partial word and any pending output word.
REQ-037 After reset is released, the first accepted beat SHALL land in lane 0.

Verification
REQ-038 DW=8, RATIO=4, ready_i=1, beats 0x11,0x22,0x33,0x44 with last_i on 0x44 -> one cycle after the 4th beat: data_o=0x44332211, keep_o=4'b1111, last_o=1, valid_o=1 for exactly one cycle.
REQ-039 Beats 0xA1,0xA2 with last_i on 0xA2 -> data_o=0x0000A2A1, keep_o=4'b0011, last_o=1; a single beat 0x5C with last_i -> data_o=0x0000005C, keep_o=4'b0001.
REQ-040 Output word pending, ready_i held 0 for 5 cycles -> data_o, keep_o and last_o stable, ready_o=0 throughout; ready_i=1 -> word transferred, ready_o=1 in the same cycle.
REQ-041 Continuous valid_i=1 with ready_i=1 for 8 beats 0x01..0x08, no last_i -> output words 0x04030201 then 0x08070605 back-to-back, last_o=0, no bubble.
REQ-042 Two beats accepted, then clear_i pulsed, then 4 beats 0xB1..0xB4 -> a single word 0xB4B3B2B1 with keep_o=4'b1111 and no trace of the first two beats; a repeat with rst_i in place of clear_i gives the same result.
REQ-043 Random valid_i and ready_i over 10k cycles, checked by a scoreboard model -> every accepted beat appears exactly once in order, and the keep_o and last_o rules above hold.
